golife_row_streamer: RTL
========================

// Module: golife_row_streamer
// PURPOSE
//  Downstream stage of golife: snapshots the SIDEWIDTH x SIDEWIDTH generation grid on request.
//  Streams the snapshot out one row per transfer over a valid/ready handshake, top row first.
//  Reports the live-cell population of the snapshot.
//  Feeds display/logging sinks so the array keeps running while a frame drains.
// PARAMETERS
//  SIDEWIDTH  16                            grid side length; grid is SIDEWIDTH rows x SIDEWIDTH bits
//  IDXW       $clog2(SIDEWIDTH)             row index width (derived, do not override)
//  CNTW       $clog2(SIDEWIDTH*SIDEWIDTH+1) population count width (derived)
// PORTS
//  clk        in   1                      single clock, all state on posedge
//  rst        in   1                      asynchronous, active-low reset
//  grid       in   [SIDEWIDTH-1:0][SIDEWIDTH-1:0]  live grid from golife; row r = grid[r]
//  capture    in   1                      snapshot request; sampled only in IDLE
//  busy       out  1                      high from snapshot until the done pulse, inclusive
//  row_data   out  SIDEWIDTH              current row of the snapshot
//  row_idx    out  IDXW                   index r of row_data
//  row_valid  out  1                      row_data/row_idx/row_last are valid
//  row_ready  in   1                      sink accepts; a transfer occurs when row_valid & row_ready
//  row_last   out  1                      high with row_idx==0
//  pop_count  out  CNTW                   total live cells of the last completed frame
//  done       out  1                      one-cycle pulse after the final transfer
//  stable     out  1                      frame identical to previous frame (STILL_DETECT_EN only)
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE; busy, row_valid, row_last, done, stable all 0.
//   Reset values continued: row_data=0, row_idx=0, pop_count=0, snapshot cleared.
//  FSM states: IDLE, STREAM, DONE.
//   IDLE -> STREAM on capture=1 at a clk edge.
//   STREAM -> DONE on a transfer with row_idx==0.
//   DONE -> IDLE after exactly one cycle.
//  Capture at edge N:
//   - grid latched into the snapshot register.
//   - from edge N: busy=1, row_valid=1, row_idx=SIDEWIDTH-1, row_data=snap[SIDEWIDTH-1].
//   - first row is therefore visible one cycle after capture is sampled.
//  Transfer rules:
//   - On each transfer, row_idx decrements and row_data advances to the next row.
//   - Back-to-back transfers give one row per cycle; a full frame takes SIDEWIDTH transfers.
//   - Outputs hold stable while row_valid & !row_ready.
//   - row_valid never drops until the transfer completes.
//  Population:
//   - Accumulator cleared at capture; adds popcount(row_data) on each transfer.
//   - pop_count register updates at the DONE entry edge and holds until the next DONE.
//  done: high exactly during the DONE cycle; row_valid=0 in DONE; busy falls on leaving DONE.
//  capture while busy (STREAM or DONE): ignored, no queuing; grid changes mid-frame do not affect the snapshot.
//  capture high in the DONE cycle: ignored; it must be held or re-asserted in IDLE.
//  Reset mid-stream: frame abandoned, all outputs return to reset values, no done pulse.
//  Widths: CNTW holds a full grid (SIDEWIDTH=16 -> 9 bits, max 256), so there is no overflow.
// CONFIGURATION
//  STILL_DETECT_EN defined:
//   - prev register + prev_valid flag (cleared by reset).
//   - At capture, compare the new grid to prev, then copy it to prev and set prev_valid.
//   - stable = (equal && prev_valid); it updates at the DONE entry edge, like pop_count.
//   - The first frame after reset reports stable=0.
//  STILL_DETECT_EN undefined: stable tied to 0; no prev register or comparator.
// STRUCTURE
//  golife_pkg: FSM state enum (IDLE/STREAM/DONE).
//   Also holds localparam helpers for IDXW/CNTW, shared with golife and the bench.
//  Sub-module golife_popcount: combinational SIDEWIDTH-bit row popcount, output $clog2(SIDEWIDTH+1) bits.
// TESTING
//  1 All-zero grid, capture, row_ready=1:
//    -> 16 transfers, idx 15..0, all rows 16'h0000, row_last on idx 0.
//    -> done one cycle later, pop_count=0.
//  2 Glider: rows 9/8/7 = 16'h0080/16'h0040/16'h01C0, all other rows 0, ready=1:
//    -> those rows stream at idx 9/8/7; pop_count=5; busy high 17 cycles.
//  3 Backpressure: row_ready low 3 cycles while row_idx=10:
//    -> row_data/row_idx held, row_valid stays 1, no skipped or duplicated row, pop_count unchanged.
//  4 capture pulsed at row_idx=5 and again in the DONE cycle:
//    -> both ignored, exactly one frame and one done pulse.
//  5 rst low while row_idx=7:
//    -> row_valid/busy/done=0 immediately.
//    -> a new capture after release streams from idx 15.
//  6 STILL_DETECT_EN: 2x2 block (rows 5,4 = 16'h0180) captured twice:
//    -> first frame stable=0, second frame stable=1.
//    -> then a glider frame gives stable=0.
//    -> without the macro, stable is always 0.

Source files
------------

// File: rtl/golife_pkg.sv
// Shared types and width helpers for the golife row streamer and its bench.
// FSM state encoding plus derived index/count widths as functions of SIDEWIDTH.
package golife_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int SIDEWIDTH_DEFAULT = 16;

    function automatic int idx_w(input int sw);
        return $clog2(sw);
    endfunction

    function automatic int cnt_w(input int sw);
        return $clog2(sw * sw + 1);
    endfunction

    function automatic int pc_w(input int sw);
        return $clog2(sw + 1);
    endfunction

endpackage

// File: rtl/golife_row_streamer_if.sv
// Row stream handshake bundle: the streamer drives data/index/valid/last, the sink drives ready.
interface golife_row_streamer_if #(
    parameter int SIDEWIDTH = 16
);
    localparam int IDXW = $clog2(SIDEWIDTH);

    logic [SIDEWIDTH-1:0] row_data;
    logic [IDXW-1:0]      row_idx;
    logic                 row_valid;
    logic                 row_ready;
    logic                 row_last;

    modport master (
        output row_data,
        output row_idx,
        output row_valid,
        output row_last,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_idx,
        input  row_valid,
        input  row_last,
        output row_ready
    );

endinterface

// File: rtl/golife_popcount.sv
// Combinational population count of one SIDEWIDTH-bit grid row.
module golife_popcount
    import golife_pkg::*;
#(
    parameter int SIDEWIDTH = 16
) (
    input  logic [SIDEWIDTH-1:0]          row,
    output logic [pc_w(SIDEWIDTH)-1:0]    count
);
    localparam int PCW = pc_w(SIDEWIDTH);

    always_comb begin
        count = '0;
        for (int i = 0; i < SIDEWIDTH; i++) begin
            count = count + PCW'(row[i]);
        end
    end

endmodule

// File: rtl/golife_row_streamer.sv
// Snapshots the golife grid on capture and streams it out top row first, one row per transfer.
// Optional still-life detection is enabled by defining STILL_DETECT_EN.
module golife_row_streamer
    import golife_pkg::*;
#(
    parameter int SIDEWIDTH = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [SIDEWIDTH-1:0][SIDEWIDTH-1:0] grid,
    input  logic                                capture,
    output logic                                busy,
    golife_row_streamer_if.master               row_if,
    output logic [cnt_w(SIDEWIDTH)-1:0]         pop_count,
    output logic                                done,
    output logic                                stable
);
    localparam int IDXW = idx_w(SIDEWIDTH);
    localparam int CNTW = cnt_w(SIDEWIDTH);
    localparam int PCW  = pc_w(SIDEWIDTH);

    state_t                              state_q, state_d;
    logic [SIDEWIDTH-1:0][SIDEWIDTH-1:0] snap_q, snap_d;
    logic [IDXW-1:0]                     idx_q, idx_d;
    logic [CNTW-1:0]                     acc_q, acc_d;
    logic [CNTW-1:0]                     pop_q, pop_d;

    logic [SIDEWIDTH-1:0] cur_row;
    logic [PCW-1:0]       row_pop;
    logic                 transfer;

`ifdef STILL_DETECT_EN
    logic [SIDEWIDTH-1:0][SIDEWIDTH-1:0] prev_q, prev_d;
    logic                                prev_valid_q, prev_valid_d;
    logic                                stable_pend_q, stable_pend_d;
    logic                                stable_q, stable_d;
`endif

    assign cur_row  = snap_q[idx_q];
    assign transfer = (state_q == STREAM) && row_if.row_ready;

    golife_popcount #(.SIDEWIDTH(SIDEWIDTH)) u_popcount (
        .row   (cur_row),
        .count (row_pop)
    );

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        pop_d   = pop_q;
`ifdef STILL_DETECT_EN
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        stable_pend_d = stable_pend_q;
        stable_d      = stable_q;
`endif
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = STREAM;
                    snap_d  = grid;
                    idx_d   = IDXW'(SIDEWIDTH - 1);
                    acc_d   = '0;
`ifdef STILL_DETECT_EN
                    // Compare against the previous snapshot before overwriting it.
                    stable_pend_d = prev_valid_q && (grid == prev_q);
                    prev_d        = grid;
                    prev_valid_d  = 1'b1;
`endif
                end
            end
            STREAM: begin
                if (transfer) begin
                    acc_d = acc_q + CNTW'(row_pop);
                    if (idx_q == '0) begin
                        state_d = DONE;
                        pop_d   = acc_q + CNTW'(row_pop);
`ifdef STILL_DETECT_EN
                        stable_d = stable_pend_q;
`endif
                    end else begin
                        idx_d = idx_q - IDXW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            pop_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            pop_q   <= pop_d;
        end
    end

`ifdef STILL_DETECT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            stable_pend_q <= 1'b0;
            stable_q      <= 1'b0;
        end else begin
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            stable_pend_q <= stable_pend_d;
            stable_q      <= stable_d;
        end
    end
    assign stable = stable_q;
`else
    assign stable = 1'b0;
`endif

    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign pop_count        = pop_q;
    assign row_if.row_data  = cur_row;
    assign row_if.row_idx   = idx_q;
    assign row_if.row_valid = (state_q == STREAM);
    assign row_if.row_last  = (state_q == STREAM) && (idx_q == '0);

endmodule
